link_frame_receiver: RTL and testbench
======================================

// Module: link_frame_receiver
// PURPOSE
//  Receive end of the sender->receiver sample link: takes the serial line bitstream, hunts for and
//  locks onto the frame sync word, deserializes payload samples, and drives the DA sample bus and
//  the sync indicator. Sits between the line decoder and the DA output stage of the receiver path.
// PARAMETERS
//  DATA_W     8        sample width (bits), payload sent MSB first
//  PAYLOAD_N  4        samples per frame
//  SYNC_W     16       sync word width
//  SYNC_WORD  16'hEB90 sync pattern, MSB first
//  LOCK_CNT   3        consecutive good sync words needed to declare lock (>=1)
//  LOSS_CNT   2        consecutive bad sync words while locked before dropping lock (>=1)
// PORTS
//  clock          in   1       single clock
//  reset          in   1       asynchronous, active-high
//  bit_in         in   1       line bit, sampled only when bit_valid=1
//  bit_valid      in   1       bit strobe; any duty cycle, may be continuous
//  da_out         out  DATA_W  last delivered sample, held between deliveries
//  da_valid       out  1       one-cycle pulse when da_out updates
//  sync_out       out  1       1 while locked
//  frame_err_cnt  out  8       saturating count of bad sync words seen while locked
// BEHAVIOUR
//  - Reset (async): state=HUNT, da_out=0, da_valid=0, sync_out=0, frame_err_cnt=0, all counters 0.
//  - Frame on line: SYNC_WORD, PAYLOAD_N*DATA_W payload bits (+1 parity bit if PARITY_EN).
//  - All state advance only on cycles with bit_valid=1; no bit_valid -> all state held, da_valid=0.
//  - HUNT: SYNC_W-bit sliding window; window==SYNC_WORD (incl. current bit) -> PAYLOAD, good_cnt=1.
//  - PAYLOAD: shift bits; every DATA_W bits completes a sample; after last payload bit -> SYNC.
//  - SYNC: collect SYNC_W bits, compare once on last bit:
//      match    -> good_cnt=min(good_cnt+1,LOCK_CNT), miss_cnt=0; good_cnt reaching LOCK_CNT sets sync_out
//                  (same cycle as state update); -> PAYLOAD.
//      mismatch -> not locked: good_cnt=0, -> HUNT (window restarts from the next bit).
//                  locked: frame_err_cnt++ (sat at 255), miss_cnt++; miss_cnt==LOSS_CNT -> sync_out=0,
//                  good_cnt=0, miss_cnt=0, -> HUNT; else flywheel -> PAYLOAD.
//  - Sample delivery only while sync_out=1 at the time the sample completes; samples of unlocked
//    frames are discarded. First delivered samples are those of the frame following the LOCK_CNT-th sync.
//  - Without PARITY_EN: da_out/da_valid registered; da_valid pulses the cycle after the bit_valid
//    carrying the sample LSB.
//  - Lock lost mid-frame is impossible (decided only at SYNC end); reset mid-frame aborts immediately.
//  - Back-to-back bit_valid at full rate must be sustained with no dropped bits.
// CONFIGURATION
//  - LINK_PARITY_EN defined: one even-parity bit follows the payload, covering all payload bits.
//    Samples are buffered in a PAYLOAD_N-entry buffer; on parity pass, released on consecutive cycles
//    (da_valid high PAYLOAD_N cycles, first the cycle after the parity bit_valid, entry 0 first);
//    on fail, frame discarded, frame_err_cnt++ (sat). Release must complete before the next frame's
//    first sample completes (guaranteed since SYNC_W >= PAYLOAD_N).
//  - Not defined: no parity bit in the frame, immediate per-sample delivery as above.
// TESTING
//  1. Reset during stream -> all outputs 0 immediately (async), HUNT resumes after release.
//  2. Continuous bit_valid, 5 clean frames, payload 20,21,22,23 each -> sync_out rises at end of the
//     3rd sync; da_out sequence 20,21,22,23 x3 with da_valid pulses, frames 1-2 produce no da_valid.
//  3. Locked, corrupt one sync word (EB91) -> frame_err_cnt=1, sync_out stays 1, next frame delivered.
//  4. Locked, corrupt two consecutive syncs -> frame_err_cnt=2, sync_out falls at 2nd bad sync end,
//     no further da_valid until re-lock after 3 good syncs.
//  5. Random garbage containing 0xEB90 once, not repeated at frame spacing -> sync_out never rises.
//  6. bit_valid every 3rd cycle, 4 clean frames -> same sample values as test 2, da_valid one cycle.
//  7. (LINK_PARITY_EN) flip one payload bit in a locked frame -> no da_valid for that frame, err=1.

Source files
------------

// File: rtl/link_frame_receiver_if.sv
// link_frame_receiver_if
//   Groups the serial line input and the DA output bus of the link frame receiver.
//   Parameter: DATA_W - sample width of da_out.
//   Signals:
//     bit_in, bit_valid - line bit and its strobe (master -> slave)
//     da_out, da_valid  - delivered sample and its one-cycle strobe (slave -> master)
//     sync_out          - high while the receiver is locked (slave -> master)
//     frame_err_cnt     - saturating bad-frame count (slave -> master)
//   Handshake: bit_valid and da_valid are plain valid strobes with no ready
//   signal. A bit is consumed on every rising clock edge where bit_valid=1,
//   and a sample is offered on every edge where da_valid=1. Neither side can
//   stall the other, so the consumer must accept every strobe.
//   Modports: master = line side (drives bits), slave = receiver.
interface link_frame_receiver_if #(
    parameter int DATA_W = 8
);
    logic              bit_in;
    logic              bit_valid;
    logic [DATA_W-1:0] da_out;
    logic              da_valid;
    logic              sync_out;
    logic [7:0]        frame_err_cnt;

    modport master (
        output bit_in, bit_valid,
        input  da_out, da_valid, sync_out, frame_err_cnt
    );

    modport slave (
        input  bit_in, bit_valid,
        output da_out, da_valid, sync_out, frame_err_cnt
    );
endinterface

// File: rtl/link_frame_receiver.sv
// link_frame_receiver
//   Receive end of the sample link. Hunts for the frame sync word in the
//   serial bitstream, locks after LOCK_CNT consecutive good syncs, flywheels
//   through up to LOSS_CNT-1 bad syncs, deserializes MSB-first payload
//   samples and drives them onto the DA bus while locked.
//   Optional feature macro: LINK_PARITY_EN - adds one even-parity bit after
//   the payload; samples are buffered and released only on parity pass.
// Ports:
//   clock      - single clock
//   reset      - asynchronous, active-high
//   lnk        - link_frame_receiver_if.slave (bit_in/bit_valid in,
//                da_out/da_valid/sync_out/frame_err_cnt out)
//   state_dbg  - current FSM state (0 HUNT, 1 PAYLOAD, 2 SYNC, 3 PARITY)
module link_frame_receiver #(
    parameter int                DATA_W    = 8,
    parameter int                PAYLOAD_N = 4,
    parameter int                SYNC_W    = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 16'hEB90,
    parameter int                LOCK_CNT  = 3,
    parameter int                LOSS_CNT  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    link_frame_receiver_if.slave  lnk,
    output logic [1:0]            state_dbg
);
    localparam int BI_W = $clog2(DATA_W);
    localparam int SI_W = (PAYLOAD_N > 1) ? $clog2(PAYLOAD_N) : 1;
    localparam int CN_W = $clog2(SYNC_W);
    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam int MC_W = $clog2(LOSS_CNT + 1);

    localparam logic [BI_W-1:0] BIT_LAST  = BI_W'(DATA_W - 1);
    localparam logic [SI_W-1:0] SAMP_LAST = SI_W'(PAYLOAD_N - 1);
    localparam logic [CN_W-1:0] SYNC_LAST = CN_W'(SYNC_W - 1);
    localparam logic [GC_W-1:0] GOOD_MAX  = GC_W'(LOCK_CNT);
    localparam logic [GC_W-1:0] GOOD_PRE  = GC_W'(LOCK_CNT - 1);
    localparam logic [MC_W-1:0] MISS_PRE  = MC_W'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        SYNC    = 2'd2,
        PARITY  = 2'd3
    } state_t;

    state_t state, state_nx;

    // The oldest window / sample bit is never needed after the compare, so
    // the shift registers hold one bit less than the full word.
    logic [SYNC_W-2:0] win;
    logic [DATA_W-2:0] sreg;
    logic [SYNC_W-1:0] win_nx;
    logic [DATA_W-1:0] sample_nx;

    // bit_cnt: window fill level in HUNT (saturates), bit position in SYNC.
    logic [CN_W-1:0]   bit_cnt;
    logic [BI_W-1:0]   bit_idx;
    logic [SI_W-1:0]   samp_idx;
    logic [GC_W-1:0]   good_cnt;
    logic [MC_W-1:0]   miss_cnt;

    logic hunt_hit, samp_done, pay_last, sync_last, sync_hit, lose;

`ifdef LINK_PARITY_EN
    logic              par;
    logic [DATA_W-1:0] samp_buf [PAYLOAD_N];
    logic              rel_active;
    logic [SI_W-1:0]   rel_idx;
`endif

    assign state_dbg = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= HUNT;
        else       state <= state_nx;
    end

    always_comb begin
        win_nx    = {win, lnk.bit_in};
        sample_nx = {sreg, lnk.bit_in};
        state_nx  = state;
        hunt_hit  = 1'b0;
        samp_done = 1'b0;
        pay_last  = 1'b0;
        sync_last = 1'b0;
        sync_hit  = 1'b0;
        lose      = 1'b0;
        if (lnk.bit_valid) begin
            case (state)
                HUNT: begin
                    // Only a completely refilled window may match.
                    if (bit_cnt == SYNC_LAST && win_nx == SYNC_WORD) begin
                        hunt_hit = 1'b1;
                        state_nx = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (bit_idx == BIT_LAST) begin
                        samp_done = 1'b1;
                        if (samp_idx == SAMP_LAST) begin
                            pay_last = 1'b1;
`ifdef LINK_PARITY_EN
                            state_nx = PARITY;
`else
                            state_nx = SYNC;
`endif
                        end
                    end
                end
                PARITY: state_nx = SYNC;
                SYNC: begin
                    if (bit_cnt == SYNC_LAST) begin
                        sync_last = 1'b1;
                        if (win_nx == SYNC_WORD) begin
                            sync_hit = 1'b1;
                            state_nx = PAYLOAD;
                        end else if (!lnk.sync_out || miss_cnt == MISS_PRE) begin
                            lose     = lnk.sync_out;
                            state_nx = HUNT;
                        end else begin
                            state_nx = PAYLOAD;   // flywheel through a bad sync
                        end
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win               <= '0;
            sreg              <= '0;
            bit_cnt           <= '0;
            bit_idx           <= '0;
            samp_idx          <= '0;
            good_cnt          <= '0;
            miss_cnt          <= '0;
            lnk.da_out        <= '0;
            lnk.da_valid      <= 1'b0;
            lnk.sync_out      <= 1'b0;
            lnk.frame_err_cnt <= '0;
`ifdef LINK_PARITY_EN
            par               <= 1'b0;
            rel_active        <= 1'b0;
            rel_idx           <= '0;
            for (int i = 0; i < PAYLOAD_N; i++) samp_buf[i] <= '0;
`endif
        end else begin
            lnk.da_valid <= 1'b0;
`ifdef LINK_PARITY_EN
            // Release of a parity-checked frame runs every cycle, independent
            // of bit_valid; it ends long before the next frame's first sample.
            if (rel_active) begin
                lnk.da_out   <= samp_buf[rel_idx];
                lnk.da_valid <= 1'b1;
                rel_idx      <= rel_idx + 1'b1;
                if (rel_idx == SAMP_LAST) rel_active <= 1'b0;
            end
`endif
            if (lnk.bit_valid) begin
                case (state)
                    HUNT: begin
                        win <= win_nx[SYNC_W-2:0];
                        if (bit_cnt != SYNC_LAST) bit_cnt <= bit_cnt + 1'b1;
                        if (hunt_hit) begin
                            good_cnt <= 1;
                            miss_cnt <= '0;
                            bit_idx  <= '0;
                            samp_idx <= '0;
                            if (LOCK_CNT == 1) lnk.sync_out <= 1'b1;
`ifdef LINK_PARITY_EN
                            par      <= 1'b0;
`endif
                        end
                    end
                    PAYLOAD: begin
                        sreg    <= sample_nx[DATA_W-2:0];
                        bit_idx <= bit_idx + 1'b1;
`ifdef LINK_PARITY_EN
                        par     <= par ^ lnk.bit_in;
`endif
                        if (samp_done) begin
                            bit_idx  <= '0;
                            samp_idx <= samp_idx + 1'b1;
`ifdef LINK_PARITY_EN
                            samp_buf[samp_idx] <= sample_nx;
`else
                            if (lnk.sync_out) begin
                                lnk.da_out   <= sample_nx;
                                lnk.da_valid <= 1'b1;
                            end
`endif
                        end
                        if (pay_last) begin
                            samp_idx <= '0;
                            bit_cnt  <= '0;
                        end
                    end
`ifdef LINK_PARITY_EN
                    PARITY: begin
                        bit_cnt <= '0;
                        par     <= 1'b0;
                        if (lnk.sync_out) begin
                            // Even parity: payload ones plus parity bit must be even.
                            if ((par ^ lnk.bit_in) == 1'b0) begin
                                lnk.da_out   <= samp_buf[0];
                                lnk.da_valid <= 1'b1;
                                rel_active   <= (PAYLOAD_N > 1);
                                rel_idx      <= SI_W'(1);
                            end else if (lnk.frame_err_cnt != 8'hFF) begin
                                lnk.frame_err_cnt <= lnk.frame_err_cnt + 1'b1;
                            end
                        end
                    end
`endif
                    SYNC: begin
                        win     <= win_nx[SYNC_W-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (sync_last) begin
                            // Also restarts the HUNT fill level on a drop.
                            bit_cnt <= '0;
                            if (sync_hit) begin
                                miss_cnt <= '0;
                                if (good_cnt >= GOOD_PRE) begin
                                    good_cnt     <= GOOD_MAX;
                                    lnk.sync_out <= 1'b1;
                                end else begin
                                    good_cnt <= good_cnt + 1'b1;
                                end
                            end else if (!lnk.sync_out) begin
                                good_cnt <= '0;
                            end else begin
                                if (lnk.frame_err_cnt != 8'hFF)
                                    lnk.frame_err_cnt <= lnk.frame_err_cnt + 1'b1;
                                if (lose) begin
                                    lnk.sync_out <= 1'b0;
                                    good_cnt     <= '0;
                                    miss_cnt     <= '0;
                                end else begin
                                    miss_cnt <= miss_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_link_frame_receiver.sv
// tb_link_frame_receiver
//   Directed bench for link_frame_receiver: lock acquisition, flywheel,
//   lock loss, false-sync rejection, async reset mid-frame, sparse bit_valid
//   and (with LINK_PARITY_EN) parity rejection. Delivered samples are
//   checked against an expected queue filled with hand-computed values.
module tb_link_frame_receiver;
    localparam logic [31:0] PAYLOAD_WORD = {8'd20, 8'd21, 8'd22, 8'd23};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state_dbg;

    link_frame_receiver_if #(.DATA_W(8)) lnk ();

    link_frame_receiver #(
        .DATA_W(8), .PAYLOAD_N(4), .SYNC_W(16), .SYNC_WORD(16'hEB90),
        .LOCK_CNT(3), .LOSS_CNT(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .lnk       (lnk),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int         n_cmp = 0;
    int         n_err = 0;
    int         gap   = 0;
    logic [7:0] exp_q[$];
    logic       prev_dv = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (lnk.da_valid === 1'b1) begin
            check_eq("da_valid_has_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("da_out", 32'(lnk.da_out), 32'(exp_q.pop_front()));
`ifndef LINK_PARITY_EN
            check_eq("da_valid_one_cycle", 32'(prev_dv), 32'd0);
`endif
        end
        prev_dv = lnk.da_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        lnk.bit_in    = b;
        lnk.bit_valid = 1'b1;
        @(negedge clock);
        if (gap > 0) begin
            lnk.bit_valid = 1'b0;
            repeat (gap) @(negedge clock);
        end
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // One frame: sync word, payload (optionally with one bit flipped), parity.
    task automatic send_frame(input logic [15:0] sw, input logic exp_sync,
                              input logic deliver, input int flip);
        logic [31:0] p;
        p = PAYLOAD_WORD;
        send_bits({16'h0, sw}, 16);
        check_eq("sync_out_after_sync", 32'(lnk.sync_out), 32'(exp_sync));
        if (deliver) for (int i = 0; i < 4; i++) exp_q.push_back(p[31-8*i -: 8]);
        if (flip >= 0) p[flip] = ~p[flip];
        send_bits(p, 32);
`ifdef LINK_PARITY_EN
        send_bit(^PAYLOAD_WORD);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        lnk.bit_in    = 1'b0;
        lnk.bit_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst_da_out",   32'(lnk.da_out),        32'd0);
        check_eq("rst_da_valid", 32'(lnk.da_valid),      32'd0);
        check_eq("rst_sync_out", 32'(lnk.sync_out),      32'd0);
        check_eq("rst_err_cnt",  32'(lnk.frame_err_cnt), 32'd0);
        check_eq("rst_state",    32'(state_dbg),         32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Five clean frames at full rate: lock at the 3rd sync, frames 3-5 delivered.
        gap = 0;
        send_frame(16'hEB90, 1'b0, 1'b0, -1);
        send_frame(16'hEB90, 1'b0, 1'b0, -1);
        send_frame(16'hEB90, 1'b1, 1'b1, -1);
        send_frame(16'hEB90, 1'b1, 1'b1, -1);
        send_frame(16'hEB90, 1'b1, 1'b1, -1);
        check_eq("t2_da_out_held", 32'(lnk.da_out), 32'd23);
        check_eq("t2_err_cnt", 32'(lnk.frame_err_cnt), 32'd0);

        // One bad sync while locked: flywheel, frame still delivered.
        send_frame(16'hEB91, 1'b1, 1'b1, -1);
        check_eq("t3_err_cnt", 32'(lnk.frame_err_cnt), 32'd1);
        send_frame(16'hEB90, 1'b1, 1'b1, -1);
        check_eq("t3_err_cnt_after_good", 32'(lnk.frame_err_cnt), 32'd1);

        // Two consecutive bad syncs: lock dropped at the second; re-lock after 3 good.
        send_frame(16'hEB91, 1'b1, 1'b1, -1);
        check_eq("t4_err_cnt_first", 32'(lnk.frame_err_cnt), 32'd2);
        send_bits(32'h0000EB91, 16);
        check_eq("t4_sync_dropped", 32'(lnk.sync_out), 32'd0);
        check_eq("t4_err_cnt_second", 32'(lnk.frame_err_cnt), 32'd3);
        check_eq("t4_state_hunt", 32'(state_dbg), 32'd0);
        send_bits(PAYLOAD_WORD, 32);
`ifdef LINK_PARITY_EN
        send_bit(^PAYLOAD_WORD);
`endif
        send_frame(16'hEB90, 1'b0, 1'b0, -1);
        send_frame(16'hEB90, 1'b0, 1'b0, -1);
        send_frame(16'hEB90, 1'b1, 1'b1, -1);
        check_eq("t4_err_cnt_relock", 32'(lnk.frame_err_cnt), 32'd3);

        // Async reset in the middle of a locked frame.
        send_bits(32'h0000EB90, 16);
        send_bits(PAYLOAD_WORD >> 26, 6);
        check_eq("t1_locked_before_reset", 32'(lnk.sync_out), 32'd1);
        #2;
        reset         = 1'b1;
        lnk.bit_valid = 1'b0;
        #1;
        check_eq("t1_async_da_out",   32'(lnk.da_out),        32'd0);
        check_eq("t1_async_sync_out", 32'(lnk.sync_out),      32'd0);
        check_eq("t1_async_err_cnt",  32'(lnk.frame_err_cnt), 32'd0);
        check_eq("t1_async_state",    32'(state_dbg),         32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Garbage with a single sync word: hunt hit, then miss, never locks.
        send_bits(32'h00001234, 16);
        send_bits(32'h0000EB90, 16);
        check_eq("t5_state_payload", 32'(state_dbg), 32'd1);
        send_bits(32'h00000000, 32);
`ifdef LINK_PARITY_EN
        send_bit(1'b0);
`endif
        send_bits(32'h00005A5A, 16);
        check_eq("t5_state_hunt", 32'(state_dbg), 32'd0);
        check_eq("t5_sync_low_a", 32'(lnk.sync_out), 32'd0);
        send_bits(32'h00000000, 32);
        send_bits(32'h00001234, 16);
        send_bits(32'h00000000, 16);
        check_eq("t5_sync_low_b", 32'(lnk.sync_out), 32'd0);
        check_eq("t5_err_cnt", 32'(lnk.frame_err_cnt), 32'd0);

        // bit_valid every 3rd cycle, four clean frames from a fresh reset.
        reset         = 1'b1;
        lnk.bit_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        gap = 2;
        send_frame(16'hEB90, 1'b0, 1'b0, -1);
        send_frame(16'hEB90, 1'b0, 1'b0, -1);
        send_frame(16'hEB90, 1'b1, 1'b1, -1);
        send_frame(16'hEB90, 1'b1, 1'b1, -1);
        check_eq("t6_da_out_held", 32'(lnk.da_out), 32'd23);

`ifdef LINK_PARITY_EN
        // Parity failure in a locked frame: frame dropped, error counted.
        gap = 0;
        send_frame(16'hEB90, 1'b1, 1'b0, 5);
        check_eq("t7_err_cnt", 32'(lnk.frame_err_cnt), 32'd1);
        send_frame(16'hEB90, 1'b1, 1'b1, -1);
        check_eq("t7_err_cnt_after_good", 32'(lnk.frame_err_cnt), 32'd1);
`endif

        lnk.bit_valid = 1'b0;
        repeat (20) @(negedge clock);
        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
